instr_fetch_unit: RTL and testbench

Multi-cycle instruction fetch stage sitting directly upstream of the decode/control path and downstream of the PC-source select. Reads the byte-wide instruction memory one byte per cycle and assembles 32-bit instruction words. Delivers each word to decode over a valid/ready handshake, with a one-word prefetch buffer. Accepts branch/jump redirects that flush all in-flight work.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_word_buffer.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the byte-serial instruction fetch stage.
// Buffer entries carry a fixed-width pc; the top level uses only its low ADDR_W bits.
package fetch_pkg;
  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;
  localparam int PC_MAX_W        = 16;

  typedef struct packed {
    logic [INSTR_W-1:0]  word;
    logic [PC_MAX_W-1:0] pc;
    logic                valid;
  } fetch_entry_t;

  function automatic logic [PC_MAX_W-1:0] pc_align(input logic [PC_MAX_W-1:0] pc);
    return {pc[PC_MAX_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_word_buffer.sv
// Two-entry word buffer: an output slot presented to decode plus one prefetch slot.
// Completed words go to the output slot when it is free, otherwise to the prefetch slot.
module fetch_word_buffer
  import fetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_ready,
  output fetch_entry_t o_head,
  output logic         o_stall
);
  fetch_entry_t r_out;
  fetch_entry_t r_pf;
  logic         w_pop;

  assign w_pop   = r_out.valid && i_ready;
  assign o_head  = r_out;
  assign o_stall = r_out.valid && r_pf.valid && !i_ready;

  // Slot update: flush, refill from prefetch on pop, or place the pushed word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= '0;
      r_pf  <= '0;
    end else if (i_flush) begin
      r_out.valid <= 1'b0;
      r_pf.valid  <= 1'b0;
    end else if (w_pop && r_pf.valid) begin
      r_out <= r_pf;
      if (i_push) begin
        r_pf <= i_push_entry;
      end else begin
        r_pf.valid <= 1'b0;
      end
    end else if (w_pop || !r_out.valid) begin
      if (i_push) begin
        r_out <= i_push_entry;
      end else begin
        r_out.valid <= 1'b0;
      end
    end else if (i_push) begin
      r_pf <= i_push_entry;
    end else begin
      r_pf <= r_pf;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch: reads one instruction byte per cycle, assembles 32-bit words
// and hands them to decode through a two-entry buffer; redirects flush everything.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int RESET_PC = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic [7:0]         i_imem_rdata,
  input  logic               i_redirect_valid,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready
);
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(BYTES_PER_INSTR);
  localparam logic [ADDR_W-1:0] BYTE_STEP  = ADDR_W'(1);

  logic [ADDR_W-1:0]   r_fpc;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_bcnt;
  logic [23:0]         r_partial;
  logic [PC_MAX_W-1:0] w_redirect_ext;
  logic [ADDR_W-1:0]   w_redirect_tgt;
  logic                w_stall;
  logic                w_push;
  fetch_entry_t        w_push_entry;
  fetch_entry_t        w_head;
  logic                w_unused_pc;

  assign w_redirect_ext = pc_align(PC_MAX_W'(i_redirect_pc));
  assign w_redirect_tgt = w_redirect_ext[ADDR_W-1:0];
  assign w_push         = !w_stall && !i_redirect_valid && (r_bcnt == 2'd3);
  assign w_push_entry   = '{word: {i_imem_rdata, r_partial}, pc: PC_MAX_W'(r_fpc), valid: 1'b1};

  assign o_imem_addr   = r_addr;
  assign o_instr       = w_head.word;
  assign o_instr_pc    = w_head.pc[ADDR_W-1:0];
  assign o_instr_valid = w_head.valid;
  assign w_unused_pc   = ^{w_head.pc, w_redirect_ext};

  // r_addr always equals r_fpc + r_bcnt, so it simply steps by one per fetched byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fpc     <= RESET_ADDR;
      r_addr    <= RESET_ADDR;
      r_bcnt    <= 2'd0;
      r_partial <= 24'd0;
    end else if (i_redirect_valid) begin
      r_fpc     <= w_redirect_tgt;
      r_addr    <= w_redirect_tgt;
      r_bcnt    <= 2'd0;
      r_partial <= 24'd0;
    end else if (!w_stall) begin
      r_addr <= r_addr + BYTE_STEP;
      r_bcnt <= r_bcnt + 2'd1;
      case (r_bcnt)
        2'd0:    r_partial[7:0]   <= i_imem_rdata;
        2'd1:    r_partial[15:8]  <= i_imem_rdata;
        2'd2:    r_partial[23:16] <= i_imem_rdata;
        2'd3:    r_fpc            <= r_fpc + WORD_STEP;
        default: r_partial        <= r_partial;
      endcase
    end else begin
      r_addr <= r_addr;
    end
  end

  fetch_word_buffer u_buf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_redirect_valid),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_ready      (i_instr_ready),
    .o_head       (w_head),
    .o_stall      (w_stall)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 32-byte memory model, hand-computed words,
// and cycle-exact checks of start-up, back-pressure, redirects, wrap and reset.
module tb_instr_fetch_unit;
  logic        clk;
  logic        rst;
  logic [4:0]  imem_addr;
  logic [7:0]  imem_rdata;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic [31:0] instr;
  logic [4:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  mem [0:31];
  int          tests;
  int          failed;

  instr_fetch_unit #(.ADDR_W(5), .RESET_PC(0)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the last reset edge, i.e. inside cycle 0.
  task automatic start_run(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 5'd0;
    instr_ready = ready;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    tick();
    tick();
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    tests++; if (instr !== 32'h0) begin failed++; $display("FAIL reset_instr: got %h want 00000000", instr); end
    tests++; if (instr_pc !== 5'd0) begin failed++; $display("FAIL reset_pc: got %0d want 0", instr_pc); end
    tests++; if (imem_addr !== 5'd0) begin failed++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
  endtask

  task automatic test_startup();
    start_run(1'b1);
    tests++; if (imem_addr !== 5'd0) begin failed++; $display("FAIL start_addr0: got %0d want 0", imem_addr); end
    repeat (3) tick();
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL start_c3_valid: got %0b want 0", instr_valid); end
    tests++; if (imem_addr !== 5'd3) begin failed++; $display("FAIL start_c3_addr: got %0d want 3", imem_addr); end
    tick();
    tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL start_c4_valid: got %0b want 1", instr_valid); end
    tests++; if (instr !== 32'h0A000220) begin failed++; $display("FAIL start_c4_instr: got %h want 0a000220", instr); end
    tests++; if (instr_pc !== 5'd0) begin failed++; $display("FAIL start_c4_pc: got %0d want 0", instr_pc); end
    tick();
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL start_c5_valid: got %0b want 0", instr_valid); end
    repeat (3) tick();
    tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL start_c8_valid: got %0b want 1", instr_valid); end
    tests++; if (instr_pc !== 5'd4) begin failed++; $display("FAIL start_c8_pc: got %0d want 4", instr_pc); end
    tests++; if (instr !== 32'h47464544) begin failed++; $display("FAIL start_c8_instr: got %h want 47464544", instr); end
  endtask

  task automatic test_back_to_back();
    start_run(1'b1);
    repeat (12) tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd8) begin failed++; $display("FAIL b2b_c12: got valid %0b pc %0d want 1 / 8", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h4B4A4948) begin failed++; $display("FAIL b2b_c12_instr: got %h want 4b4a4948", instr); end
    repeat (4) tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd12) begin failed++; $display("FAIL b2b_c16: got valid %0b pc %0d want 1 / 12", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h4F4E4D4C) begin failed++; $display("FAIL b2b_c16_instr: got %h want 4f4e4d4c", instr); end
  endtask

  task automatic test_backpressure();
    start_run(1'b0);
    repeat (4) tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin failed++; $display("FAIL bp_c4: got valid %0b pc %0d want 1 / 0", instr_valid, instr_pc); end
    repeat (3) tick();
    tests++; if (imem_addr !== 5'd7) begin failed++; $display("FAIL bp_c7_addr: got %0d want 7", imem_addr); end
    tick();
    tests++; if (imem_addr !== 5'd8) begin failed++; $display("FAIL bp_c8_addr: got %0d want 8", imem_addr); end
    tests++; if (instr !== 32'h0A000220 || instr_pc !== 5'd0) begin failed++; $display("FAIL bp_c8_hold: got %h pc %0d want 0a000220 / 0", instr, instr_pc); end
    repeat (2) tick();
    tests++; if (imem_addr !== 5'd8) begin failed++; $display("FAIL bp_c10_addr: got %0d want 8", imem_addr); end
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin failed++; $display("FAIL bp_c10_hold: got valid %0b pc %0d want 1 / 0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd4) begin failed++; $display("FAIL bp_c11: got valid %0b pc %0d want 1 / 4", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h47464544) begin failed++; $display("FAIL bp_c11_instr: got %h want 47464544", instr); end
    tests++; if (imem_addr !== 5'd9) begin failed++; $display("FAIL bp_c11_addr: got %0d want 9", imem_addr); end
    tick();
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL bp_c12_valid: got %0b want 0", instr_valid); end
    repeat (2) tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd8) begin failed++; $display("FAIL bp_c14: got valid %0b pc %0d want 1 / 8", instr_valid, instr_pc); end
  endtask

  task automatic test_redirect_mid();
    start_run(1'b1);
    repeat (10) tick();
    tests++; if (imem_addr !== 5'd10) begin failed++; $display("FAIL rmid_c10_addr: got %0d want 10", imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc = 5'd14;
    tick();
    redirect_valid = 1'b0;
    tests++; if (imem_addr !== 5'd12) begin failed++; $display("FAIL rmid_c11_addr: got %0d want 12", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rmid_c11_valid: got %0b want 0", instr_valid); end
    repeat (3) tick();
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rmid_c14_valid: got %0b want 0", instr_valid); end
    tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd12) begin failed++; $display("FAIL rmid_c15: got valid %0b pc %0d want 1 / 12", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h4F4E4D4C) begin failed++; $display("FAIL rmid_c15_instr: got %h want 4f4e4d4c", instr); end
  endtask

  task automatic test_redirect_full();
    start_run(1'b0);
    repeat (9) tick();
    tests++; if (instr_valid !== 1'b1 || imem_addr !== 5'd8) begin failed++; $display("FAIL rfull_c9: got valid %0b addr %0d want 1 / 8", instr_valid, imem_addr); end
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 5'd16;
    tick();
    redirect_valid = 1'b0;
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rfull_c10_valid: got %0b want 0", instr_valid); end
    tests++; if (imem_addr !== 5'd16) begin failed++; $display("FAIL rfull_c10_addr: got %0d want 16", imem_addr); end
    repeat (3) tick();
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rfull_c13_valid: got %0b want 0", instr_valid); end
    tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd16) begin failed++; $display("FAIL rfull_c14: got valid %0b pc %0d want 1 / 16", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h53525150) begin failed++; $display("FAIL rfull_c14_instr: got %h want 53525150", instr); end
  endtask

  task automatic test_wrap();
    start_run(1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 5'd28;
    tick();
    redirect_valid = 1'b0;
    tests++; if (imem_addr !== 5'd28) begin failed++; $display("FAIL wrap_c1_addr: got %0d want 28", imem_addr); end
    repeat (4) tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd28) begin failed++; $display("FAIL wrap_c5: got valid %0b pc %0d want 1 / 28", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h5F5E5D5C) begin failed++; $display("FAIL wrap_c5_instr: got %h want 5f5e5d5c", instr); end
    tests++; if (imem_addr !== 5'd0) begin failed++; $display("FAIL wrap_c5_addr: got %0d want 0", imem_addr); end
    repeat (4) tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin failed++; $display("FAIL wrap_c9: got valid %0b pc %0d want 1 / 0", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h0A000220) begin failed++; $display("FAIL wrap_c9_instr: got %h want 0a000220", instr); end
  endtask

  task automatic test_reset_mid();
    start_run(1'b0);
    repeat (7) tick();
    tests++; if (instr_valid !== 1'b1 || imem_addr !== 5'd7) begin failed++; $display("FAIL rstmid_pre: got valid %0b addr %0d want 1 / 7", instr_valid, imem_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_ready = 1'b1;
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rstmid_valid: got %0b want 0", instr_valid); end
    tests++; if (instr !== 32'h0) begin failed++; $display("FAIL rstmid_instr: got %h want 00000000", instr); end
    tests++; if (imem_addr !== 5'd0) begin failed++; $display("FAIL rstmid_addr: got %0d want 0", imem_addr); end
    repeat (3) tick();
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rstmid_c3_valid: got %0b want 0", instr_valid); end
    tick();
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 5'd0) begin failed++; $display("FAIL rstmid_c4: got valid %0b pc %0d want 1 / 0", instr_valid, instr_pc); end
    tests++; if (instr !== 32'h0A000220) begin failed++; $display("FAIL rstmid_c4_instr: got %h want 0a000220", instr); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 5'd0;
    instr_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i) + 8'h40;
    mem[0] = 8'h20;
    mem[1] = 8'h02;
    mem[2] = 8'h00;
    mem[3] = 8'h0A;
    test_reset();
    test_startup();
    test_back_to_back();
    test_backpressure();
    test_redirect_mid();
    test_redirect_full();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
